// File: rtl/traffic_light_pkg.sv
// Shared types and constants for the traffic-light monitor: lamp encodings, phases,
// error codes and the monitor FSM state.
package traffic_light_pkg;

    localparam logic [2:0] LAMP_OFF = 3'b000;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_R   = 3'b100;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_G    = 2'd1,
        PH_Y    = 2'd2,
        PH_R    = 2'd3
    } phase_e;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_ENC    = 3'd1;
    localparam logic [2:0] ERR_SEQ    = 3'd2;
    localparam logic [2:0] ERR_STEP   = 3'd3;
    localparam logic [2:0] ERR_RELOAD = 3'd4;
    localparam logic [2:0] ERR_STALL  = 3'd5;

    typedef enum logic {
        MON_INIT = 1'b0,
        MON_RUN  = 1'b1
    } mon_state_e;

    function automatic logic lamp_legal(logic [2:0] c);
        return (c == LAMP_OFF) || (c == LAMP_G) || (c == LAMP_Y) || (c == LAMP_R);
    endfunction

    function automatic phase_e lamp2phase(logic [2:0] c);
        case (c)
            LAMP_G:  return PH_G;
            LAMP_Y:  return PH_Y;
            LAMP_R:  return PH_R;
            default: return PH_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Lamp/countdown bus from the controller plus the monitor's error/status outputs.
interface traffic_light_monitor_if;
    logic [2:0]  light_ctrl;
    logic [3:0]  light_t;
    logic        clr_err;
    logic [1:0]  phase;
    logic        err_valid;
    logic [2:0]  err_code;
    logic        err_sticky;
    logic [15:0] cycle_cnt;

    modport master (
        output light_ctrl, light_t, clr_err,
        input  phase, err_valid, err_code, err_sticky, cycle_cnt
    );

    modport slave (
        input  light_ctrl, light_t, clr_err,
        output phase, err_valid, err_code, err_sticky, cycle_cnt
    );
endinterface

// File: rtl/tlm_input_sync.sv
// Two-flop synchroniser for the lamp/countdown inputs when they come from another clock domain.
module tlm_input_sync #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/traffic_light_monitor.sv
// Checks lamp encoding, phase order, countdown steps, reloads and liveness of the light controller.
// Define TLM_SYNC_EN to put 2-flop synchronisers on light_ctrl/light_t.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter logic [3:0]  G_T       = 4'd10,
    parameter logic [3:0]  Y_T       = 4'd5,
    parameter logic [3:0]  R_T       = 4'd15,
    parameter logic [31:0] STALL_MAX = 32'd100_000_000
) (
    input logic                    sys_clk,
    input logic                    sys_rst_p,
    traffic_light_monitor_if.slave mon
);
    logic [6:0] in_s;
    logic [2:0] ctrl_s;
    logic [3:0] t_s;

`ifdef TLM_SYNC_EN
    tlm_input_sync #(.W(7)) u_sync (
        .clk (sys_clk),
        .rst (sys_rst_p),
        .d_i ({mon.light_ctrl, mon.light_t}),
        .q_o (in_s)
    );
`else
    assign in_s = {mon.light_ctrl, mon.light_t};
`endif
    assign ctrl_s = in_s[6:4];
    assign t_s    = in_s[3:0];

    mon_state_e  state_q, state_d;
    logic [2:0]  prev_ctrl_q, prev_ctrl_d;
    logic [3:0]  prev_t_q, prev_t_d;
    phase_e      phase_q, phase_d;
    logic [31:0] stall_q, stall_d;
    logic [15:0] cycle_q, cycle_d;
    logic        err_valid_q, err_valid_d;
    logic        err_sticky_q, err_sticky_d;
    logic [2:0]  err_code_q, err_code_d;

    logic       evt, stall_hit, seq_ok;
    logic [3:0] reload;
    logic [2:0] code;

    assign evt = ({ctrl_s, t_s} != {prev_ctrl_q, prev_t_q});

    always_comb begin
        state_d     = state_q;
        prev_ctrl_d = prev_ctrl_q;
        prev_t_d    = prev_t_q;
        phase_d     = phase_q;
        stall_d     = stall_q;
        cycle_d     = cycle_q;
        stall_hit   = 1'b0;
        code        = ERR_NONE;

        case (ctrl_s)
            LAMP_G:  reload = G_T;
            LAMP_Y:  reload = Y_T;
            LAMP_R:  reload = R_T;
            default: reload = 4'd0;
        endcase
        seq_ok = (prev_ctrl_q == LAMP_OFF && ctrl_s == LAMP_G) ||
                 (prev_ctrl_q == LAMP_G   && ctrl_s == LAMP_Y) ||
                 (prev_ctrl_q == LAMP_Y   && ctrl_s == LAMP_R) ||
                 (prev_ctrl_q == LAMP_R   && ctrl_s == LAMP_G);

        case (state_q)
            MON_INIT: begin
                prev_ctrl_d = ctrl_s;
                prev_t_d    = t_s;
                if (lamp_legal(ctrl_s)) phase_d = lamp2phase(ctrl_s);
                stall_d     = '0;
                state_d     = MON_RUN;
            end
            default: begin
                if (evt) begin
                    prev_ctrl_d = ctrl_s;
                    prev_t_d    = t_s;
                    stall_d     = '0;
                    if (lamp_legal(ctrl_s)) phase_d = lamp2phase(ctrl_s);
                    if (prev_ctrl_q == LAMP_R && ctrl_s == LAMP_G) cycle_d = cycle_q + 16'd1;
                end else if (stall_q == STALL_MAX - 32'd1) begin
                    stall_d   = '0;
                    stall_hit = 1'b1;
                end else begin
                    stall_d = stall_q + 32'd1;
                end

                // Encoding is checked every cycle; everything else only on events.
                if (!lamp_legal(ctrl_s))                code = ERR_ENC;
                else if (evt && ctrl_s != prev_ctrl_q) begin
                    if (!seq_ok)                        code = ERR_SEQ;
                    else if (prev_t_q != 4'd1)          code = ERR_STEP;
                    else if (t_s != reload)             code = ERR_RELOAD;
                end else if (evt) begin
                    if (prev_t_q == 4'd1 || t_s != prev_t_q - 4'd1) code = ERR_STEP;
                end else if (stall_hit)                 code = ERR_STALL;
            end
        endcase

        err_valid_d  = (code != ERR_NONE);
        err_sticky_d = err_sticky_q;
        err_code_d   = err_code_q;
        // A new error beats a simultaneous clear; otherwise the first error is held.
        if (err_valid_d) begin
            err_sticky_d = 1'b1;
            if (!err_sticky_q || mon.clr_err) err_code_d = code;
        end else if (mon.clr_err) begin
            err_sticky_d = 1'b0;
            err_code_d   = ERR_NONE;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst_p) begin
        if (sys_rst_p) begin
            state_q      <= MON_INIT;
            prev_ctrl_q  <= '0;
            prev_t_q     <= '0;
            phase_q      <= PH_IDLE;
            stall_q      <= '0;
            cycle_q      <= '0;
            err_valid_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            prev_ctrl_q  <= prev_ctrl_d;
            prev_t_q     <= prev_t_d;
            phase_q      <= phase_d;
            stall_q      <= stall_d;
            cycle_q      <= cycle_d;
            err_valid_q  <= err_valid_d;
            err_sticky_q <= err_sticky_d;
            err_code_q   <= err_code_d;
        end
    end

    assign mon.phase      = phase_q;
    assign mon.err_valid  = err_valid_q;
    assign mon.err_code   = err_code_q;
    assign mon.err_sticky = err_sticky_q;
    assign mon.cycle_cnt  = cycle_q;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench: stimulus pushes expected error pulses into a scoreboard, a negedge monitor pops them.
module tb_traffic_light_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    traffic_light_monitor_if tl_if ();

    traffic_light_monitor #(.STALL_MAX(32'd20)) dut (
        .sys_clk   (clk),
        .sys_rst_p (rst),
        .mon       (tl_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] due;
        logic [2:0]  code;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [1:0] exp_ph;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every err_valid pulse must match the oldest expectation, at its due cycle.
    always @(negedge clk) begin
        if (tl_if.err_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_err_valid", 32'(tl_if.err_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("err_valid_cycle", cyc, mon_e.due);
                check("err_code", 32'(tl_if.err_code), 32'(mon_e.code));
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            check("missing_err_valid", 32'(tl_if.err_valid), 32'd1);
            mon_e = sb.pop_front();
        end
    end

    // shown != 0 means an error pulse is expected with err_code == shown.
    task automatic drive(logic [2:0] c, logic [3:0] t, logic clr = 1'b0, logic [2:0] shown = 3'd0);
        exp_t e;
        tl_if.light_ctrl = c;
        tl_if.light_t    = t;
        tl_if.clr_err    = clr;
        if (shown != 3'd0) begin
            e.due  = cyc + 1;
            e.code = shown;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        tl_if.clr_err = 1'b0;
        case (c)
            3'b000: exp_ph = 2'd0;
            3'b001: exp_ph = 2'd1;
            3'b010: exp_ph = 2'd2;
            3'b100: exp_ph = 2'd3;
            default: ;
        endcase
        check("phase", 32'(tl_if.phase), 32'(exp_ph));
    endtask

    task automatic run(logic [2:0] c, int from, int to);
        for (int v = from; v >= to; v--) drive(c, 4'(v));
    endtask

    task automatic check_outputs_zero(string tag);
        check({tag, "_phase"},     32'(tl_if.phase),      32'd0);
        check({tag, "_err_valid"}, 32'(tl_if.err_valid),  32'd0);
        check({tag, "_err_code"},  32'(tl_if.err_code),   32'd0);
        check({tag, "_err_sticky"},32'(tl_if.err_sticky), 32'd0);
        check({tag, "_cycle_cnt"}, 32'(tl_if.cycle_cnt),  32'd0);
    endtask

    initial begin
        tl_if.light_ctrl = 3'b001;
        tl_if.light_t    = 4'd10;
        tl_if.clr_err    = 1'b0;
        exp_ph           = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_ph = 2'd1;
        check("init_phase", 32'(tl_if.phase), 32'd1);

        // Three full legal G-Y-R cycles
        for (int k = 0; k < 3; k++) begin
            run(3'b001, 9, 1);
            run(3'b010, 5, 1);
            run(3'b100, 15, 1);
            drive(3'b001, 4'd10);
        end
        check("legal_cycle_cnt", 32'(tl_if.cycle_cnt), 32'd3);
        check("legal_sticky", 32'(tl_if.err_sticky), 32'd0);

        // Illegal transition Y -> G
        run(3'b001, 9, 1);
        run(3'b010, 5, 1);
        drive(3'b001, 4'd10, 1'b0, 3'd2);
        check("seq_code", 32'(tl_if.err_code), 32'd2);
        drive(3'b001, 4'd9, 1'b1);
        check("clr_sticky", 32'(tl_if.err_sticky), 32'd0);
        check("clr_code", 32'(tl_if.err_code), 32'd0);

        // Countdown skip, then a second (different) error keeps the first code
        drive(3'b001, 4'd8);
        drive(3'b001, 4'd7);
        drive(3'b001, 4'd5, 1'b0, 3'd3);
        drive(3'b001, 4'd4);
        drive(3'b100, 4'd15, 1'b0, 3'd3);
        check("first_wins_code", 32'(tl_if.err_code), 32'd3);
        drive(3'b100, 4'd14, 1'b1);
        check("clr2_sticky", 32'(tl_if.err_sticky), 32'd0);
        run(3'b100, 13, 1);
        drive(3'b001, 4'd10);
        check("cycle_cnt_4", 32'(tl_if.cycle_cnt), 32'd4);

        // Bad reload, then illegal encoding together with clr_err
        run(3'b001, 9, 1);
        drive(3'b010, 4'd4, 1'b0, 3'd4);
        drive(3'b011, 4'd4, 1'b1, 3'd1);
        check("enc_clr_sticky", 32'(tl_if.err_sticky), 32'd1);
        check("enc_clr_code", 32'(tl_if.err_code), 32'd1);
        drive(3'b010, 4'd3, 1'b0, 3'd1);
        drive(3'b010, 4'd2, 1'b1);
        drive(3'b010, 4'd1);
        check("pre_stall_sticky", 32'(tl_if.err_sticky), 32'd0);

        // Stall: Y/1 held; pulses after 20 and 40 quiet cycles
        for (int k = 1; k <= 45; k++)
            drive(3'b010, 4'd1, 1'b0, (k == 20 || k == 40) ? 3'd5 : 3'd0);
        check("stall_code", 32'(tl_if.err_code), 32'd5);
        check("stall_sticky", 32'(tl_if.err_sticky), 32'd1);

        // Asynchronous reset mid-Y, release with a mid-count R sample
        #2;
        rst = 1'b1;
        #1;
        check_outputs_zero("async_rst");
        tl_if.light_ctrl = 3'b100;
        tl_if.light_t    = 4'd9;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_ph = 2'd3;
        check("rst_init_phase", 32'(tl_if.phase), 32'd3);
        check("rst_init_sticky", 32'(tl_if.err_sticky), 32'd0);
        run(3'b100, 8, 1);
        drive(3'b001, 4'd10);
        check("rst_cycle_cnt", 32'(tl_if.cycle_cnt), 32'd1);
        check("rst_final_sticky", 32'(tl_if.err_sticky), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
